// File: rtl/mem_boot_pkg.sv
// rtl/mem_boot_pkg.sv - shared widths and FSM state codes for the boot loader
package mem_boot_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int BYTE_W     = 8;
  localparam int STATE_W    = 4;

  localparam logic [STATE_W-1:0] S_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] S_LEN_HI  = 4'd1;
  localparam logic [STATE_W-1:0] S_LEN_LO  = 4'd2;
  localparam logic [STATE_W-1:0] S_DATA_HI = 4'd3;
  localparam logic [STATE_W-1:0] S_DATA_LO = 4'd4;
  localparam logic [STATE_W-1:0] S_WRITE   = 4'd5;
  localparam logic [STATE_W-1:0] S_CSUM    = 4'd6;
  localparam logic [STATE_W-1:0] S_FIN     = 4'd7;
  localparam logic [STATE_W-1:0] S_ERR     = 4'd8;

endpackage

// File: rtl/mem_boot_loader.sv
// rtl/mem_boot_loader.sv - streams a length-prefixed byte image into the 16-bit program memory
// Optional trailing XOR checksum byte enabled by MEM_BOOT_CHECKSUM_EN.
module mem_boot_loader
  import mem_boot_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [BYTE_W-1:0]     rx_data,
  output logic                  rx_ready,
  output logic                  MemWrite,
  output logic [ADDR_W-1:0]     Address,
  output logic [MEM_DATA_W-1:0] WriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W:0]       words_loaded
);

  logic [STATE_W-1:0]    state;
  logic [BYTE_W-1:0]     len_hi;
  logic [MEM_DATA_W-1:0] len;
  logic [MEM_DATA_W-1:0] len_in;
  logic [ADDR_W:0]       words_next;
  logic                  xfer;
  logic                  too_big;
  logic                  last_word;

`ifdef MEM_BOOT_CHECKSUM_EN
  localparam logic [STATE_W-1:0] S_TAIL = S_CSUM;
  logic [BYTE_W-1:0] csum;
`else
  localparam logic [STATE_W-1:0] S_TAIL = S_FIN;
`endif

  // Ready is a pure function of state so the host handshake has no combinational loop.
  always_comb begin
    rx_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
               (state == S_DATA_HI) || (state == S_DATA_LO) ||
               (state == S_CSUM);
    MemWrite = (state == S_WRITE);
  end

  assign xfer       = rx_valid && rx_ready;
  assign len_in     = {len_hi, rx_data};
  assign too_big    = 32'(len_in) > (32'd1 << ADDR_W);
  assign words_next = words_loaded + 1'b1;
  assign last_word  = 32'(words_next) == 32'(len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      len_hi       <= '0;
      len          <= '0;
      Address      <= BASE_ADDR;
      WriteData    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            Address      <= BASE_ADDR;
            busy         <= 1'b1;
            state        <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len <= len_in;
            if (len_in == '0) begin
              state <= S_TAIL;
            end else if (too_big) begin
              state <= S_ERR;
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            WriteData[15:8] <= rx_data;
            state           <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            WriteData[7:0] <= rx_data;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Address wraps naturally at the memory depth; wrap is a legal image layout.
          Address      <= Address + 1'b1;
          words_loaded <= words_next;
          state        <= last_word ? S_TAIL : S_DATA_HI;
        end
`ifdef MEM_BOOT_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            state <= (rx_data == csum) ? S_FIN : S_ERR;
          end
        end
`endif
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_BOOT_CHECKSUM_EN
  // Running XOR covers data bytes only, never the length header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (state == S_IDLE && start) begin
      csum <= '0;
    end else if (xfer && (state == S_DATA_HI || state == S_DATA_LO)) begin
      csum <= csum ^ rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_boot_loader.sv
// tb/tb_mem_boot_loader.sv - randomized self-checking bench for mem_boot_loader
module tb_mem_boot_loader;

  localparam int AW = 12;
  localparam logic [AW-1:0] WBASE = 12'hFFF;

  logic clk = 1'b0;
  logic rst, start, rx_valid;
  logic [7:0] rx_data;

  logic rdy_a, mw_a, busy_a, done_a, err_a;
  logic [AW-1:0] addr_a;
  logic [15:0] wd_a;
  logic [AW:0] wl_a;

  logic rdy_b, mw_b, busy_b, done_b, err_b;
  logic [AW-1:0] addr_b;
  logic [15:0] wd_b;
  logic [AW:0] wl_b;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  logic [AW+15:0] wq_a[$];
  logic [AW+15:0] wq_b[$];
  logic [15:0] words[$];
  logic [7:0]  img[$];

  always #5 clk = ~clk;

  mem_boot_loader #(.ADDR_W(AW), .BASE_ADDR(12'h000)) u_dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy_a), .MemWrite(mw_a), .Address(addr_a), .WriteData(wd_a),
    .busy(busy_a), .done(done_a), .error(err_a), .words_loaded(wl_a)
  );

  mem_boot_loader #(.ADDR_W(AW), .BASE_ADDR(WBASE)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy_b), .MemWrite(mw_b), .Address(addr_b), .WriteData(wd_b),
    .busy(busy_b), .done(done_b), .error(err_b), .words_loaded(wl_b)
  );

  // Write-port monitor: every MemWrite-high cycle is one logged write.
  always @(negedge clk) begin
    if (!rst) begin
      if (mw_a) wq_a.push_back({addr_a, wd_a});
      if (mw_b) wq_b.push_back({addr_b, wd_b});
      if (mw_a && rdy_a) viol++;
      if (mw_a && !busy_a) viol++;
      if (rdy_a !== rdy_b) viol++;
    end
  end

  task automatic make_image(input bit good_csum);
    logic [7:0] x;
    x = 8'h00;
    img.delete();
    img.push_back(8'(words.size() >> 8));
    img.push_back(8'(words.size()));
    foreach (words[i]) begin
      img.push_back(words[i][15:8]);
      img.push_back(words[i][7:0]);
      x = x ^ words[i][15:8] ^ words[i][7:0];
    end
`ifdef MEM_BOOT_CHECKSUM_EN
    img.push_back(good_csum ? x : 8'hFF);
`else
    if (!good_csum) x = 8'h00;
`endif
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input bit gaps, output bit to);
    int idx = 0;
    int cyc = 0;
    while (idx < img.size() && cyc < 4000) begin
      @(negedge clk);
      rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      rx_data  = rx_valid ? img[idx] : 8'($urandom);
      if (rx_valid && rdy_a) idx++;
      cyc++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    to = (idx < img.size());
  endtask

  task automatic wait_idle(output bit to);
    int c = 0;
    while (busy_a && c < 200) begin
      @(negedge clk);
      c++;
    end
    to = busy_a;
  endtask

  task automatic run_image(input bit gaps, output bit to);
    bit t1, t2;
    wq_a.delete();
    wq_b.delete();
    do_start();
    send_bytes(gaps, t1);
    wait_idle(t2);
    to = t1 | t2;
  endtask

  task automatic test_reset();
    checks++;
    if ({rdy_a, mw_a, busy_a, done_a, err_a} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {rdy_a, mw_a, busy_a, done_a, err_a});
    end
    checks++;
    if (addr_a !== 12'h000 || wd_a !== 16'h0 || wl_a !== '0) begin
      failures++; $display("FAIL reset_regs got addr=%h wd=%h wl=%0d exp 000/0000/0", addr_a, wd_a, wl_a);
    end
    checks++;
    if (addr_b !== WBASE) begin
      failures++; $display("FAIL reset_base got=%h exp=%h", addr_b, WBASE);
    end
  endtask

  task automatic test_idle_ignored();
    bit to;
    int bad = 0;
    rx_valid = 1'b1;
    rx_data = 8'h5A;
    repeat (5) begin
      @(negedge clk);
      if (rdy_a !== 1'b0) bad++;
    end
    rx_valid = 1'b0;
    checks++;
    if (bad != 0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL idle_ready got bad_cycles=%0d busy=%b exp 0/0", bad, busy_a);
    end
    words = '{16'hC0DE};
    make_image(1'b1);
    run_image(1'b0, to);
    checks++;
    if (to || wq_a.size() != 1 || wq_a[0] !== {12'h000, 16'hC0DE}) begin
      failures++; $display("FAIL idle_then_load got n=%0d to=%0d exp one write 000:c0de", wq_a.size(), to);
    end
  endtask

  task automatic test_normal(input bit gaps, input string tag);
    bit to;
    logic [AW+15:0] ea, eb;
    words = '{16'h1234, 16'hABCD};
    make_image(1'b1);
    run_image(gaps, to);
    checks++;
    if (to || wq_a.size() != 2 || wq_b.size() != 2) begin
      failures++; $display("FAIL %s_count got a=%0d b=%0d to=%0d exp 2/2/0", tag, wq_a.size(), wq_b.size(), to);
    end
    for (int i = 0; i < 2; i++) begin
      ea = {AW'(i), words[i]};
      eb = {WBASE + AW'(i), words[i]};
      checks++;
      if (i < wq_a.size() && wq_a[i] !== ea) begin
        failures++; $display("FAIL %s_write%0d got=%h exp=%h", tag, i, wq_a[i], ea);
      end
      checks++;
      if (i < wq_b.size() && wq_b[i] !== eb) begin
        failures++; $display("FAIL %s_wrapwrite%0d got=%h exp=%h", tag, i, wq_b[i], eb);
      end
    end
    checks++;
    if ({done_a, err_a, busy_a} !== 3'b100 || wl_a !== 13'd2 || addr_a !== 12'h002) begin
      failures++; $display("FAIL %s_status got d/e/b=%b wl=%0d addr=%h exp 100/2/002", tag, {done_a, err_a, busy_a}, wl_a, addr_a);
    end
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL %s_protocol got violations=%0d exp=0", tag, viol);
    end
  endtask

  task automatic test_zero_length();
    bit to;
    words.delete();
    make_image(1'b1);
    run_image(1'b0, to);
    checks++;
    if (to || wq_a.size() != 0 || done_a !== 1'b1 || err_a !== 1'b0) begin
      failures++; $display("FAIL zero_len got writes=%0d done=%b err=%b to=%0d exp 0/1/0/0", wq_a.size(), done_a, err_a, to);
    end
  endtask

  task automatic test_oversize();
    bit to;
    img = '{8'h10, 8'h01};
    wq_a.delete();
    do_start();
    send_bytes(1'b0, to);
    wait_idle(to);
    repeat (3) @(negedge clk);
    checks++;
    if (err_a !== 1'b1 || done_a !== 1'b0 || wq_a.size() != 0 || rdy_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL oversize got err=%b done=%b writes=%0d rdy=%b busy=%b exp 1/0/0/0/0",
                           err_a, done_a, wq_a.size(), rdy_a, busy_a);
    end
  endtask

  task automatic test_wrap();
    bit to;
    words = '{16'h1111, 16'h2222};
    make_image(1'b1);
    run_image(1'b1, to);
    checks++;
    if (to || wq_b.size() != 2 || wq_b[0] !== {12'hFFF, 16'h1111} || wq_b[1] !== {12'h000, 16'h2222}) begin
      failures++; $display("FAIL wrap got n=%0d first=%h exp fff1111,0002222", wq_b.size(), wq_b.size() > 0 ? wq_b[0] : '0);
    end
    checks++;
    if (done_b !== 1'b1 || err_b !== 1'b0 || addr_b !== 12'h001) begin
      failures++; $display("FAIL wrap_status got done=%b err=%b addr=%h exp 1/0/001", done_b, err_b, addr_b);
    end
  endtask

  task automatic test_random();
    bit to;
    int n;
    int bad;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 7);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back(16'($urandom));
      make_image(1'b1);
      run_image(1'b1, to);
      bad = 0;
      if (wq_a.size() != n || wq_b.size() != n) bad++;
      for (int k = 0; k < n && k < wq_a.size() && k < wq_b.size(); k++) begin
        if (wq_a[k] !== {AW'(k), words[k]}) bad++;
        if (wq_b[k] !== {WBASE + AW'(k), words[k]}) bad++;
      end
      checks++;
      if (to || bad != 0 || done_a !== 1'b1 || 32'(wl_a) != n) begin
        failures++; $display("FAIL random%0d got bad=%0d done=%b wl=%0d to=%0d exp 0/1/%0d/0", it, bad, done_a, wl_a, to, n);
      end
    end
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL random_protocol got violations=%0d exp=0", viol);
    end
  endtask

  task automatic test_start_ignored();
    int idx = 0;
    bit to;
    words = '{16'h1234};
    make_image(1'b1);
    wq_a.delete();
    do_start();
    while (idx < img.size()) begin
      @(negedge clk);
      start = (idx == 3);
      rx_valid = 1'b1;
      rx_data = img[idx];
      if (rdy_a) idx++;
    end
    @(negedge clk);
    start = 1'b0;
    rx_valid = 1'b0;
    wait_idle(to);
    checks++;
    if (to || wq_a.size() != 1 || wq_a[0] !== {12'h000, 16'h1234} || done_a !== 1'b1) begin
      failures++; $display("FAIL start_busy got n=%0d done=%b to=%0d exp 1 write 0001234 done=1", wq_a.size(), done_a, to);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int c = 0;
    words = '{16'hAABB, 16'hCCDD, 16'hEEFF};
    make_image(1'b1);
    wq_a.delete();
    do_start();
    img = img[0:3];
    send_bytes(1'b0, to);
    while (wq_a.size() == 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rdy_a, mw_a, busy_a, done_a, err_a} !== 5'b0 || addr_a !== 12'h000 || wd_a !== 16'h0 || wl_a !== '0) begin
      failures++; $display("FAIL reset_mid got flags=%b addr=%h wd=%h wl=%0d exp all zero",
                           {rdy_a, mw_a, busy_a, done_a, err_a}, addr_a, wd_a, wl_a);
    end
    checks++;
    if (c >= 50 || wq_a.size() != 1 || wq_a[0] !== {12'h000, 16'hAABB}) begin
      failures++; $display("FAIL reset_mid_first got n=%0d exp 1 write 000aabb", wq_a.size());
    end
    @(negedge clk);
    rst = 1'b0;
    words = '{16'h0102, 16'h0304, 16'h0506};
    make_image(1'b1);
    run_image(1'b1, to);
    checks++;
    if (to || wq_a.size() != 3 || wq_a[2] !== {12'h002, 16'h0506} || done_a !== 1'b1 || wl_a !== 13'd3) begin
      failures++; $display("FAIL reset_mid_reload got n=%0d done=%b wl=%0d to=%0d exp 3/1/3/0", wq_a.size(), done_a, wl_a, to);
    end
  endtask

`ifdef MEM_BOOT_CHECKSUM_EN
  task automatic test_bad_checksum();
    bit to;
    words = '{16'h1234, 16'hABCD};
    make_image(1'b0);
    run_image(1'b0, to);
    checks++;
    if (to || err_a !== 1'b1 || done_a !== 1'b0 || wq_a.size() != 2) begin
      failures++; $display("FAIL bad_csum got err=%b done=%b writes=%0d to=%0d exp 1/0/2/0", err_a, done_a, wq_a.size(), to);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_idle_ignored();
    test_normal(1'b0, "normal");
    test_zero_length();
    test_oversize();
    test_normal(1'b1, "backpressure");
    test_wrap();
    test_random();
    test_start_ignored();
    test_reset_mid();
`ifdef MEM_BOOT_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
